equeuels_ord: RTL

- Parametrised, age-ordered load/store issue queue for the Tomasulo back end.
- Accepts load/store micro-ops from dispatch and holds them in a circular buffer.
- Snoops the CDB to wake up pending base (rs) and store-data (rt) operands.
- Issues strictly in program order to the memory stage, with base+offset address formed at the output.

---
 rtl/equeuels_ord_if.sv | 60 ++++++
 rtl/equeuels_ord.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/equeuels_ord_if.sv
// equeuels_ord_if
//   Handshake/bus bundle between dispatch, the CDB, the memory stage and the
//   age-ordered load/store issue queue.
//   Groups:
//     dispatch_* : micro-op write port (opcode, imm, tags, operand data/valids,
//                  dispatch_en request, dispatch_ready back-pressure)
//     cdb_*      : common data bus broadcast (valid, tag, data)
//     issue_*    : head-of-queue issue port (valid/ready handshake, opcode,
//                  formed address, store data, destination tag)
//   Modports:
//     master : the environment side (dispatch, CDB, memory stage)
//     slave  : the issue queue
interface equeuels_ord_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
);
  logic              dispatch_opcode;
  logic [IMM_W-1:0]  dispatch_imm;
  logic [TAG_W-1:0]  dispatch_rdtag;
  logic [TAG_W-1:0]  dispatch_rstag;
  logic [TAG_W-1:0]  dispatch_rttag;
  logic [DATA_W-1:0] dispatch_rsdata;
  logic [DATA_W-1:0] dispatch_rtdata;
  logic              dispatch_rsvalid;
  logic              dispatch_rtvalid;
  logic              dispatch_en;
  logic              dispatch_ready;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              issue_valid;
  logic              issue_ready;
  logic              issue_opcode;
  logic [DATA_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_rtdata;
  logic [TAG_W-1:0]  issue_rdtag;

  modport master (
    output dispatch_opcode, dispatch_imm, dispatch_rdtag, dispatch_rstag,
           dispatch_rttag, dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid,
           dispatch_rtvalid, dispatch_en,
           cdb_valid, cdb_tag, cdb_data,
           issue_ready,
    input  dispatch_ready,
           issue_valid, issue_opcode, issue_addr, issue_rtdata, issue_rdtag
  );

  modport slave (
    input  dispatch_opcode, dispatch_imm, dispatch_rdtag, dispatch_rstag,
           dispatch_rttag, dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid,
           dispatch_rtvalid, dispatch_en,
           cdb_valid, cdb_tag, cdb_data,
           issue_ready,
    output dispatch_ready,
           issue_valid, issue_opcode, issue_addr, issue_rtdata, issue_rdtag
  );
endinterface

// File: rtl/equeuels_ord.sv
// equeuels_ord
//   Age-ordered load/store issue queue. Micro-ops are written at the tail of a
//   circular buffer, wake their base (rs) and store-data (rt) operands from CDB
//   broadcasts, and leave strictly in program order from the head. The memory
//   address (base + sign-extended offset) is formed at the output.
//   Ports:
//     clk    : clock
//     reset  : synchronous active-high reset
//     flush  : synchronous clear of all entries (mispredict recovery)
//     bus    : equeuels_ord_if.slave (dispatch, CDB and issue groups)
module equeuels_ord #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  equeuels_ord_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg;

  logic              busy_reg    [DEPTH];
  logic              opcode_reg  [DEPTH];
  logic [IMM_W-1:0]  imm_reg     [DEPTH];
  logic [TAG_W-1:0]  rdtag_reg   [DEPTH];
  logic [TAG_W-1:0]  rstag_reg   [DEPTH];
  logic [TAG_W-1:0]  rttag_reg   [DEPTH];
  logic [DATA_W-1:0] rsdata_reg  [DEPTH];
  logic [DATA_W-1:0] rtdata_reg  [DEPTH];
  logic              rsvalid_reg [DEPTH];
  logic              rtvalid_reg [DEPTH];

  logic              clear;
  logic              can_accept;
  logic              head_ready;
  logic              do_dispatch;
  logic              do_pop;
  logic              rs_bypass;
  logic              rt_bypass;
  logic [DEPTH-1:0]  wr_sel;
  logic [DEPTH-1:0]  pop_sel;
  logic [DEPTH-1:0]  rs_wake;
  logic [DEPTH-1:0]  rt_wake;

  // Flush shares the reset path and overrides any same-cycle dispatch/pop.
  assign clear = reset | flush;

  // Full blocks dispatch even when the head pops this cycle (no pass-through).
  assign can_accept = (count_reg != CNT_W'(DEPTH));

  // Issue readiness looks only at registered state, so a CDB wakeup in cycle N
  // makes the head issuable in cycle N+1 at the earliest.
  assign head_ready = busy_reg[head_reg] && rsvalid_reg[head_reg] &&
                      (!opcode_reg[head_reg] || rtvalid_reg[head_reg]);

  assign do_dispatch = bus.dispatch_en && can_accept;
  assign do_pop      = head_ready && bus.issue_ready;

  // A missing operand whose producer is on the CDB this very cycle is captured
  // at dispatch instead of waiting for a broadcast that has already gone by.
  assign rs_bypass = !bus.dispatch_rsvalid && bus.cdb_valid &&
                     (bus.cdb_tag == bus.dispatch_rstag);
  assign rt_bypass = !bus.dispatch_rtvalid && bus.cdb_valid &&
                     (bus.cdb_tag == bus.dispatch_rttag);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
      assign wr_sel[gi]  = do_dispatch && (tail_reg == IDX);
      assign pop_sel[gi] = do_pop && (head_reg == IDX);
      assign rs_wake[gi] = busy_reg[gi] && !rsvalid_reg[gi] && bus.cdb_valid &&
                           (bus.cdb_tag == rstag_reg[gi]);
      assign rt_wake[gi] = busy_reg[gi] && !rtvalid_reg[gi] && bus.cdb_valid &&
                           (bus.cdb_tag == rttag_reg[gi]);
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_dispatch) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)      head_reg <= head_reg + PTR_W'(1);
      case ({do_dispatch, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage. The tail slot written by dispatch is never the head slot
  // being popped (that would need the queue to be both full and empty), so the
  // write and pop/wakeup branches are mutually exclusive per entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clear) begin
        busy_reg[i]    <= 1'b0;
        rsvalid_reg[i] <= 1'b0;
        rtvalid_reg[i] <= 1'b0;
      end else if (wr_sel[i]) begin
        busy_reg[i]    <= 1'b1;
        opcode_reg[i]  <= bus.dispatch_opcode;
        imm_reg[i]     <= bus.dispatch_imm;
        rdtag_reg[i]   <= bus.dispatch_rdtag;
        rstag_reg[i]   <= bus.dispatch_rstag;
        rttag_reg[i]   <= bus.dispatch_rttag;
        rsvalid_reg[i] <= bus.dispatch_rsvalid | rs_bypass;
        rtvalid_reg[i] <= bus.dispatch_rtvalid | rt_bypass;
        rsdata_reg[i]  <= rs_bypass ? bus.cdb_data : bus.dispatch_rsdata;
        rtdata_reg[i]  <= rt_bypass ? bus.cdb_data : bus.dispatch_rtdata;
      end else begin
        if (pop_sel[i]) busy_reg[i] <= 1'b0;
        if (rs_wake[i]) begin
          rsdata_reg[i]  <= bus.cdb_data;
          rsvalid_reg[i] <= 1'b1;
        end
        if (rt_wake[i]) begin
          rtdata_reg[i]  <= bus.cdb_data;
          rtvalid_reg[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.dispatch_ready = can_accept;
  assign bus.issue_valid    = head_ready;
  assign bus.issue_opcode   = opcode_reg[head_reg];
  assign bus.issue_addr     = rsdata_reg[head_reg] +
                              DATA_W'($signed(imm_reg[head_reg]));
  assign bus.issue_rtdata   = rtdata_reg[head_reg];
  assign bus.issue_rdtag    = rdtag_reg[head_reg];
endmodule
